// File: rtl/if_stage_pkg.sv
// Shared types and helpers for the MINA2000 instruction fetch stage.
package if_stage_pkg;

    typedef logic [31:0] u32_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Payload handed to the IF/ID register.
    typedef struct packed {
        u32_t ir;
        u32_t ia_plus_4;
    } id_params_t;

    // One fetched instruction waiting in the output buffer.
    typedef struct packed {
        u32_t ir;
        u32_t ia_plus_4;
    } fetch_entry_t;

    // Force an address onto an instruction boundary.
    function automatic u32_t word_align(input u32_t addr);
        return addr & ~u32_t'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; read data is the current head (no read latency).
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A pop frees a slot, so a push into a full FIFO is allowed in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking; flush discards everything including same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited request issue, response pairing and squash.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        id_ready,
    output logic        id_valid,
    output id_params_t  id_params
);
    localparam int CW = $clog2(DEPTH) + 1;

    u32_t          r_pc;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_drop_next;
    logic [CW-1:0] w_outstanding;

    // The address FIFO holds one entry per un-answered fetch, so its count is in_flight.
    u32_t          w_addr_head;
    logic [CW-1:0] w_in_flight;
    logic          w_addr_full;
    logic          w_addr_empty;

    fetch_entry_t  w_buf_din;
    logic [$bits(fetch_entry_t)-1:0] w_buf_dout;
    logic [CW-1:0] w_buf_count;
    logic          w_buf_full;
    logic          w_buf_empty;

    logic          w_has_credit;
    logic          w_issue;
    u32_t          w_pc_plus_4;
    logic          w_rsp_drop;
    logic          w_rsp_accept;

    // Credits cover both words still in memory and words waiting for ID.
    assign w_has_credit   = (w_in_flight + w_buf_count) < CW'(DEPTH);
    assign imem_req_valid = rst_n && !redirect_valid && w_has_credit && !w_addr_full;
    assign imem_req_addr  = r_pc;
    assign w_issue        = imem_req_valid && imem_req_ready;
    assign w_pc_plus_4    = r_pc + u32_t'(INSTR_BYTES);

    // Stale words are eaten first; a word with nothing outstanding is simply ignored.
    assign w_rsp_drop   = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_accept = imem_rsp_valid && (r_drop_cnt == '0) && !w_addr_empty
                          && !redirect_valid && !w_buf_full;

    assign w_buf_din = '{ir: imem_rsp_data, ia_plus_4: w_addr_head};

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_issue),
        .i_din   (w_pc_plus_4),
        .i_pop   (w_rsp_accept),
        .i_flush (redirect_valid),
        .o_dout  (w_addr_head),
        .o_count (w_in_flight),
        .o_full  (w_addr_full),
        .o_empty (w_addr_empty)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_accept),
        .i_din   (w_buf_din),
        .i_pop   (id_ready && !w_buf_empty),
        .i_flush (redirect_valid),
        .o_dout  (w_buf_dout),
        .o_count (w_buf_count),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    assign id_valid  = !w_buf_empty;
    assign id_params = id_valid ? id_params_t'(w_buf_dout) : '0;

    // Outstanding responses after a redirect: everything already owed, less the word
    // arriving now (a kept word is discarded by the flush, a stale one is consumed).
    assign w_outstanding = r_drop_cnt + w_in_flight;

    // Next value of the squash counter.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_next = w_outstanding - CW'(imem_rsp_valid && (w_outstanding != '0));
        end else if (w_rsp_drop) begin
            w_drop_next = r_drop_cnt - CW'(1);
        end
    end

    // PC and squash counter; redirect overrides any issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_ADDR;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
            if (redirect_valid) begin
                r_pc <= word_align(redirect_addr);
            end else if (w_issue) begin
                r_pc <= w_pc_plus_4;
            end
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((r_drop_cnt != '0) || !w_addr_empty));

endmodule

// File: tb/tb_if_stage.sv
// Directed and random checks of if_stage against an in-order instruction stream model.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int   DEPTH      = 2;
    localparam u32_t WRAP_RESET = 32'hFFFF_FFF8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       imem_req_valid, imem_req_ready, imem_rsp_valid;
    u32_t       imem_req_addr, imem_rsp_data, redirect_addr;
    logic       redirect_valid, id_ready, id_valid;
    id_params_t id_params;

    logic       w2_req_valid, w2_req_ready, w2_rsp_valid;
    u32_t       w2_req_addr, w2_rsp_data, w2_redirect_addr;
    logic       w2_redirect_valid, w2_id_ready, w2_id_valid;
    id_params_t w2_id_params;

    if_stage #(.RESET_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .id_ready(id_ready),
        .id_valid(id_valid), .id_params(id_params)
    );

    if_stage #(.RESET_ADDR(WRAP_RESET), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w2_req_valid), .imem_req_ready(w2_req_ready),
        .imem_req_addr(w2_req_addr), .imem_rsp_valid(w2_rsp_valid),
        .imem_rsp_data(w2_rsp_data), .redirect_valid(w2_redirect_valid),
        .redirect_addr(w2_redirect_addr), .id_ready(w2_id_ready),
        .id_valid(w2_id_valid), .id_params(w2_id_params)
    );

    typedef struct { int due; u32_t addr; } mreq_t;
    mreq_t mq[$];

    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, lat = 1, n_issued = 0, n_pops = 0, n2_pops = 0;
    logic g_req_rdy = 1'b1, g_id_rdy = 1'b1;
    u32_t exp_req, exp_id, exp2_req, exp2_id, prev2_addr;
    logic prev2_hs = 1'b0, prev_stall = 1'b0, prev_redirect = 1'b0;
    id_params_t prev_params;

    // Memory contents: arbitrary but address-dependent words.
    function automatic u32_t mem_word(input u32_t a);
        return (a ^ 32'h5A5A_1234) * 32'h0001_0003 + 32'h0000_9E37;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the edge, then observe settled outputs.
    task automatic do_cycle(input logic rdir, input u32_t raddr);
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = rdir;
        redirect_addr  = raddr;
        imem_req_ready = g_req_rdy;
        id_ready       = g_id_rdy;
        w2_req_ready   = 1'b1;
        if (mq.size() != 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        w2_rsp_valid = prev2_hs;
        w2_rsp_data  = mem_word(prev2_addr);
        #1;
        if (prev_redirect) chk("id_valid_after_redirect", 64'(id_valid), 64'd0);
        if (rdir)          chk("no_issue_on_redirect", 64'(imem_req_valid), 64'd0);
        if (prev_stall)    chk("stall_hold_params", id_params, prev_params);
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", 64'(imem_req_addr), 64'(exp_req));
            mq.push_back('{cyc + lat, imem_req_addr});
            exp_req += 32'd4;
            n_issued++;
        end
        if (id_valid && id_ready) begin
            $display("cyc=%0d pop ia_plus_4=%h ir=%h", cyc, id_params.ia_plus_4, id_params.ir);
            chk("id_params", id_params, {mem_word(exp_id), exp_id + 32'd4});
            exp_id += 32'd4;
            n_pops++;
        end
        prev_stall    = id_valid && !id_ready && !rdir;
        prev_params   = id_params;
        prev_redirect = rdir;
        if (rdir) begin
            exp_req = raddr & ~32'h3;
            exp_id  = raddr & ~32'h3;
        end
        if (w2_req_valid) begin
            chk("wrap_req_addr", 64'(w2_req_addr), 64'(exp2_req));
            exp2_req += 32'd4;
        end
        prev2_hs   = w2_req_valid;
        prev2_addr = w2_req_addr;
        if (w2_id_valid) begin
            chk("wrap_id_params", w2_id_params, {mem_word(exp2_id), exp2_id + 32'd4});
            exp2_id += 32'd4;
            n2_pops++;
        end
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for a clock.
    task automatic do_reset(input int new_lat);
        rst_n = 1'b0;
        #1;
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_id_params", id_params, 64'd0);
        chk("rst_wrap_id_valid", 64'(w2_id_valid), 64'd0);
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
        w2_rsp_valid = 1'b0; w2_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mq.delete();
        lat = new_lat;
        exp_req = 32'h0; exp_id = 32'h0;
        exp2_req = WRAP_RESET; exp2_id = WRAP_RESET;
        prev2_hs = 1'b0; prev_stall = 1'b0; prev_redirect = 1'b0;
        n2_pops = 0;
    endtask

    initial begin
        int n0;
        u32_t p0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_addr = '0; id_ready = 1'b1;
        w2_req_ready = 1'b0; w2_rsp_valid = 1'b0; w2_rsp_data = '0;
        w2_redirect_valid = 1'b0; w2_redirect_addr = '0; w2_id_ready = 1'b1;
        #1;

        // 1: single-cycle memory, first instruction at ID two cycles after first request
        do_reset(1);
        do_cycle(1'b0, '0);
        chk("t1_req_valid_c0", 64'(imem_req_valid), 64'd1);
        chk("t1_id_valid_c0", 64'(id_valid), 64'd0);
        do_cycle(1'b0, '0);
        chk("t1_id_valid_c1", 64'(id_valid), 64'd0);
        do_cycle(1'b0, '0);
        chk("t1_id_valid_c2", 64'(id_valid), 64'd1);
        repeat (6) do_cycle(1'b0, '0);
        chk("t1_stream_progress", 64'(exp_id >= 32'h10), 64'd1);
        // 5: the wrap instance has run alongside from FFFF_FFF8 through 0
        chk("t5_wrap_progress", 64'(n2_pops >= 3), 64'd1);

        // 2: stall holds the buffer and stops issue once credits are used
        n0 = n_issued;
        g_id_rdy = 1'b0;
        repeat (5) do_cycle(1'b0, '0);
        chk("t2_stall_issue_bound", 64'((n_issued - n0) <= DEPTH), 64'd1);
        chk("t2_stall_req_off", 64'(imem_req_valid), 64'd0);
        chk("t2_stall_id_valid", 64'(id_valid), 64'd1);
        g_id_rdy = 1'b1;
        p0 = exp_id;
        repeat (6) do_cycle(1'b0, '0);
        chk("t2_resume", 64'(exp_id > p0), 64'd1);

        // 3: latency 3, two in flight, redirect squashes both
        do_reset(3);
        n0 = n_issued;
        repeat (2) do_cycle(1'b0, '0);
        chk("t3_two_in_flight", 64'(n_issued - n0), 64'd2);
        do_cycle(1'b1, 32'h0000_0100);
        repeat (12) do_cycle(1'b0, '0);
        chk("t3_new_stream", 64'(exp_id >= 32'h108), 64'd1);

        // 4: back-to-back redirects, the later target wins
        do_reset(2);
        repeat (3) do_cycle(1'b0, '0);
        do_cycle(1'b1, 32'h0000_0040);
        do_cycle(1'b1, 32'h0000_0080);
        repeat (12) do_cycle(1'b0, '0);
        chk("t4_last_redirect", 64'(exp_id >= 32'h88), 64'd1);

        // 6: unaligned redirect, then reset mid-stream restarts at the reset address
        do_reset(1);
        do_cycle(1'b1, 32'h0000_0103);
        repeat (6) do_cycle(1'b0, '0);
        chk("t6_aligned_stream", 64'(exp_id >= 32'h104), 64'd1);
        do_reset(1);
        repeat (6) do_cycle(1'b0, '0);
        chk("t6_restart", 64'(exp_id >= 32'h8), 64'd1);

        // Random traffic: ready jitter, stalls and redirects, then a drain
        for (int r = 0; r < 4; r++) begin
            do_reset(int'($urandom_range(1, 3)));
            for (int i = 0; i < 80; i++) begin
                g_req_rdy = ($urandom % 4) != 0;
                g_id_rdy  = ($urandom % 3) != 0;
                do_cycle(($urandom % 12) == 0, $urandom & 32'h0000_0FFF);
            end
            g_req_rdy = 1'b1;
            g_id_rdy  = 1'b1;
            n0 = n_pops;
            repeat (16) do_cycle(1'b0, '0);
            chk("rand_drain_progress", 64'((n_pops - n0) >= 3), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
